// File: rtl/captura_teclado.sv
// Key-entry controller: turns the scanner's multiplexed key code into debounced
// one-shot key events, edits a BCD entry buffer and hands committed numbers off over valid/ready.
module captura_teclado #(
   parameter int SCAN_PERIOD  = 200,
   parameter int DEBOUNCE_WIN = 5,
   parameter int N_DIGITS     = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [3:0]                    boton,
   output logic [4*N_DIGITS-1:0]         entrada,
   output logic [$clog2(N_DIGITS+1)-1:0] n_dig,
   output logic                          tecla_evento,
   output logic [3:0]                    tecla_codigo,
   output logic [4*N_DIGITS-1:0]         dato,
   output logic                          dato_valido,
   input  logic                          dato_listo
);

   localparam int VW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int RW = (DEBOUNCE_WIN > 1) ? $clog2(DEBOUNCE_WIN + 1) : 1;
   localparam int NW = $clog2(N_DIGITS + 1);
   localparam int BW = 4 * N_DIGITS;

   localparam logic [3:0] K_NINGUNA = 4'hF;
   localparam logic [3:0] K_COMMIT  = 4'hA;
   localparam logic [3:0] K_BORRA   = 4'hB;
   localparam logic [3:0] K_LIMPIA  = 4'hE;

   typedef enum logic {REPOSO, PULSADA} estado_t;

   // ---------------------------------------------------------------- window sampler
   logic [VW-1:0] r_ventana;
   logic [3:0]    r_latch;        // K_NINGUNA means nothing captured yet
   logic          w_cierre;
   logic [3:0]    w_resultado;

   assign w_cierre    = (r_ventana == VW'(SCAN_PERIOD - 1));
   // A code sampled in the closing cycle still belongs to this window.
   assign w_resultado = (r_latch != K_NINGUNA) ? r_latch : boton;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ventana <= '0;
         r_latch   <= K_NINGUNA;
      end else if (w_cierre) begin
         r_ventana <= '0;
         r_latch   <= K_NINGUNA;
      end else begin
         r_ventana <= r_ventana + 1'b1;
         if (r_latch == K_NINGUNA)
            r_latch <= boton;
      end
   end

   // ---------------------------------------------------------------- debounce
   logic [3:0]    r_previo;
   logic [RW-1:0] r_racha;
   logic [3:0]    r_estable;
   logic [RW-1:0] w_racha_nx;
   logic          w_cambio;

   always_comb begin
      w_racha_nx = RW'(1);
      if (w_resultado == r_previo)
         w_racha_nx = (r_racha == RW'(DEBOUNCE_WIN)) ? r_racha : r_racha + 1'b1;
   end

   assign w_cambio = w_cierre && (w_racha_nx == RW'(DEBOUNCE_WIN)) &&
                     (w_resultado != r_estable);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_previo  <= K_NINGUNA;
         r_racha   <= '0;
         r_estable <= K_NINGUNA;
      end else if (w_cierre) begin
         r_previo <= w_resultado;
         r_racha  <= w_racha_nx;
         if (w_cambio)
            r_estable <= w_resultado;
      end
   end

   // ---------------------------------------------------------------- press FSM
   estado_t r_estado, w_estado_nx;
   logic    w_evento;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_estado <= REPOSO;
      else        r_estado <= w_estado_nx;
   end

   // Events fire on the same edge the stable code updates, so the pulse lands
   // in the first cycle after the deciding window closes.
   always_comb begin
      w_estado_nx = r_estado;
      w_evento    = 1'b0;
      case (r_estado)
         REPOSO: begin
            if (w_cambio && w_resultado != K_NINGUNA) begin
               w_evento    = 1'b1;
               w_estado_nx = PULSADA;
            end
         end
         PULSADA: begin
            if (w_cambio && w_resultado == K_NINGUNA)
               w_estado_nx = REPOSO;
         end
         default: w_estado_nx = REPOSO;
      endcase
   end

   // ---------------------------------------------------------------- entry buffer and hand-off
   logic [BW-1:0] r_entrada, w_entrada_nx;
   logic [NW-1:0] r_n_dig,   w_n_dig_nx;
   logic [BW-1:0] r_dato,    w_dato_nx;
   logic          r_valido,  w_valido_nx;
   logic          r_evento;
   logic [3:0]    r_codigo;

   always_comb begin
      w_entrada_nx = r_entrada;
      w_n_dig_nx   = r_n_dig;
      w_dato_nx    = r_dato;
      w_valido_nx  = (r_valido && dato_listo) ? 1'b0 : r_valido;
      if (w_evento) begin
         if (w_resultado <= 4'd9) begin
            if (r_n_dig < NW'(N_DIGITS)) begin
               w_entrada_nx = (r_entrada << 4) | BW'(w_resultado);
               w_n_dig_nx   = r_n_dig + 1'b1;
            end
         end else if (w_resultado == K_LIMPIA) begin
            w_entrada_nx = '0;
            w_n_dig_nx   = '0;
         end else if (w_resultado == K_BORRA) begin
            if (r_n_dig != '0) begin
               w_entrada_nx = r_entrada >> 4;
               w_n_dig_nx   = r_n_dig - 1'b1;
            end
         end else if (w_resultado == K_COMMIT) begin
            // Consumer taking the old value this cycle frees the slot for the new one.
            if (r_n_dig != '0 && (!r_valido || dato_listo)) begin
               w_dato_nx    = r_entrada;
               w_valido_nx  = 1'b1;
               w_entrada_nx = '0;
               w_n_dig_nx   = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entrada <= '0;
         r_n_dig   <= '0;
         r_dato    <= '0;
         r_valido  <= 1'b0;
         r_evento  <= 1'b0;
         r_codigo  <= K_NINGUNA;
      end else begin
         r_entrada <= w_entrada_nx;
         r_n_dig   <= w_n_dig_nx;
         r_dato    <= w_dato_nx;
         r_valido  <= w_valido_nx;
         r_evento  <= w_evento;
         if (w_evento)
            r_codigo <= w_resultado;
      end
   end

   assign entrada      = r_entrada;
   assign n_dig        = r_n_dig;
   assign dato         = r_dato;
   assign dato_valido  = r_valido;
   assign tecla_evento = r_evento;
   assign tecla_codigo = r_codigo;

endmodule

// File: tb/tb_captura_teclado.sv
// Bench for captura_teclado: directed key sequences plus random typing, checked
// every cycle against a window/run-length model of the key-entry rules.
module tb_captura_teclado;
   localparam int SP = 8;
   localparam int DW = 3;
   localparam int ND = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  boton = 4'hF;
   logic        dato_listo = 1'b0;
   logic [15:0] entrada, dato;
   logic [2:0]  n_dig;
   logic        tecla_evento, dato_valido;
   logic [3:0]  tecla_codigo;

   always #5 clk = ~clk;

   captura_teclado #(.SCAN_PERIOD(SP), .DEBOUNCE_WIN(DW), .N_DIGITS(ND)) dut (
      .clk(clk), .rst_n(rst_n), .boton(boton),
      .entrada(entrada), .n_dig(n_dig),
      .tecla_evento(tecla_evento), .tecla_codigo(tecla_codigo),
      .dato(dato), .dato_valido(dato_valido), .dato_listo(dato_listo)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- cycle counter since reset release
   int ncyc = 0;
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) ncyc = 0;
      else        ncyc++;
   end

   // ---------------------------------------------------------------- behavioural model
   int          m_cnt = 0;
   int          m_first = 15;
   int          hist[$];
   int          m_stable = 15;
   int          m_buf[$];
   logic [15:0] m_entrada = '0;
   int          m_n = 0;
   logic [15:0] m_dato = '0;
   bit          m_valid = 1'b0;
   int          m_code = 15;
   bit          m_evt = 1'b0;

   function automatic logic [15:0] pack();
      logic [15:0] v;
      v = '0;
      foreach (m_buf[i]) v = (v << 4) | 16'(m_buf[i]);
      return v;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_cnt = 0; m_first = 15; hist.delete(); m_stable = 15;
         m_buf.delete(); m_dato = '0; m_valid = 1'b0; m_code = 15; m_evt = 1'b0;
      end else begin : step
         int res;
         bit commit, v0, same;
         v0 = m_valid; commit = 1'b0; m_evt = 1'b0;
         if (m_first == 15 && boton != 4'hF) m_first = int'(boton);
         if (m_cnt == SP - 1) begin
            res = m_first; m_first = 15; m_cnt = 0;
            hist.push_back(res);
            if (hist.size() > DW) void'(hist.pop_front());
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != res) same = 1'b0;
            if (same && hist.size() == DW && res != m_stable) begin
               if (m_stable == 15) begin
                  m_evt = 1'b1; m_code = res;
                  if (res <= 9) begin
                     if (m_buf.size() < ND) m_buf.push_back(res);
                  end else if (res == 14) m_buf.delete();
                  else if (res == 11) begin
                     if (m_buf.size() > 0) void'(m_buf.pop_back());
                  end else if (res == 10) begin
                     if (m_buf.size() > 0 && (!v0 || dato_listo)) begin
                        m_dato = pack(); m_buf.delete(); commit = 1'b1;
                     end
                  end
               end
               m_stable = res;
            end
         end else m_cnt++;
         if (commit) m_valid = 1'b1;
         else if (v0 && dato_listo) m_valid = 1'b0;
      end
      m_entrada = pack();
      m_n = m_buf.size();
   end

   // ---------------------------------------------------------------- per-cycle compare + event monitor
   int         evt_cnt = 0;
   int         last_evt_cyc = -1;
   logic [3:0] last_evt_code = 4'hF;

   initial forever begin
      @(negedge clk);
      chk("entrada", 32'(entrada), 32'(m_entrada));
      chk("n_dig", 32'(n_dig), 32'(m_n));
      chk("tecla_evento", 32'(tecla_evento), 32'(m_evt));
      chk("tecla_codigo", 32'(tecla_codigo), 32'(m_code));
      chk("dato", 32'(dato), 32'(m_dato));
      chk("dato_valido", 32'(dato_valido), 32'(m_valid));
      if (tecla_evento) begin
         evt_cnt++;
         last_evt_cyc  = ncyc;
         last_evt_code = tecla_codigo;
      end
   end

   // ---------------------------------------------------------------- stimulus
   logic [3:0] cur_key = 4'hF;
   int         key_off = 0;
   bit         rnd_listo = 1'b0;
   bit         noise = 1'b0;

   // Key visible in 2 of every 8 cycles, as the column scan would present it.
   task automatic drive_cycle();
      logic [3:0] b;
      int ph;
      b  = 4'hF;
      ph = (ncyc + key_off) % SP;
      if (cur_key != 4'hF && (ph == 2 || ph == 3)) b = cur_key;
      if (noise && $urandom_range(0, 31) == 0) b = 4'($urandom_range(0, 15));
      boton = b;
      if (rnd_listo) dato_listo = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      #2;
   endtask

   task automatic win(input int n);
      repeat (n * SP) drive_cycle();
   endtask

   task automatic align();
      while (ncyc % SP != 0) drive_cycle();
   endtask

   task automatic press(input logic [3:0] k, input int hold, input int rel);
      align();
      cur_key = k; win(hold);
      cur_key = 4'hF; win(rel);
   endtask

   int e0;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_entrada", 32'(entrada), 32'h0);
      chk("rst_codigo", 32'(tecla_codigo), 32'hF);
      chk("rst_valido", 32'(dato_valido), 32'h0);

      // first press: event exactly at cycle 24
      cur_key = 4'h1;
      rst_n = 1'b1;
      win(5);
      cur_key = 4'hF; win(3);
      chk("p1_events", 32'(evt_cnt), 32'd1);
      chk("p1_evt_cycle", 32'(last_evt_cyc), 32'd24);
      chk("p1_codigo", 32'(last_evt_code), 32'h1);
      chk("p1_entrada", 32'(entrada), 32'h0001);
      chk("p1_n_dig", 32'(n_dig), 32'd1);

      press(4'hE, 3, 3);
      e0 = evt_cnt;
      for (int d = 1; d <= 5; d++) press(4'(d), 3, 3);
      chk("type5_events", 32'(evt_cnt - e0), 32'd5);
      chk("type5_entrada", 32'(entrada), 32'h1234);
      chk("type5_n_dig", 32'(n_dig), 32'd4);
      chk("model_1234", 32'(m_entrada), 32'h1234);

      press(4'hB, 3, 3);
      chk("bksp_entrada", 32'(entrada), 32'h0123);
      chk("bksp_n_dig", 32'(n_dig), 32'd3);
      press(4'hE, 3, 3);
      chk("clr_entrada", 32'(entrada), 32'h0);
      chk("clr_n_dig", 32'(n_dig), 32'd0);

      press(4'h7, 3, 3); press(4'h8, 3, 3); press(4'hA, 3, 3);
      chk("commit_dato", 32'(dato), 32'h0078);
      chk("commit_valido", 32'(dato_valido), 32'h1);
      chk("commit_entrada", 32'(entrada), 32'h0);
      chk("model_dato", 32'(m_dato), 32'h0078);

      press(4'h9, 3, 3); press(4'hA, 3, 3);
      chk("busy_entrada", 32'(entrada), 32'h0009);
      chk("busy_n_dig", 32'(n_dig), 32'd1);
      chk("busy_dato", 32'(dato), 32'h0078);

      dato_listo = 1'b1;
      @(posedge clk); #2;
      dato_listo = 1'b0;
      chk("ack_valido", 32'(dato_valido), 32'h0);

      // glitch: two windows only
      e0 = evt_cnt;
      press(4'h1, 2, 3);
      chk("glitch_events", 32'(evt_cnt - e0), 32'd0);
      chk("glitch_entrada", 32'(entrada), 32'h0009);

      // slide 1 -> 2 without a release window
      align();
      e0 = evt_cnt;
      cur_key = 4'h1; win(3);
      cur_key = 4'h2; win(3);
      cur_key = 4'hF; win(3);
      chk("slide_events", 32'(evt_cnt - e0), 32'd1);
      chk("slide_codigo", 32'(tecla_codigo), 32'h1);
      chk("slide_entrada", 32'(entrada), 32'h0091);

      // reset while 5 is held
      align();
      cur_key = 4'h5; win(2);
      rst_n = 1'b0;
      drive_cycle(); drive_cycle();
      chk("mid_rst_entrada", 32'(entrada), 32'h0);
      chk("mid_rst_n_dig", 32'(n_dig), 32'd0);
      chk("mid_rst_codigo", 32'(tecla_codigo), 32'hF);
      chk("mid_rst_valido", 32'(dato_valido), 32'h0);
      e0 = evt_cnt;
      rst_n = 1'b1;
      win(4);
      chk("rst_press_events", 32'(evt_cnt - e0), 32'd1);
      chk("rst_press_cycle", 32'(last_evt_cyc), 32'd24);
      chk("rst_press_codigo", 32'(last_evt_code), 32'h5);
      cur_key = 4'hF; win(3);

      // random typing with noise and random consumer back-pressure
      rnd_listo = 1'b1;
      noise = 1'b1;
      repeat (120) begin
         key_off = $urandom_range(0, SP - 1);
         cur_key = 4'($urandom_range(0, 14));
         win($urandom_range(1, 5));
         if ($urandom_range(0, 3) != 0) begin
            cur_key = 4'hF;
            win($urandom_range(1, 5));
         end
      end
      noise = 1'b0;
      cur_key = 4'hF;
      win(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/captura_teclado.md
# captura_teclado

Key-entry controller that sits downstream of the 4x4 matrix keypad scanner. It turns the scanner's time-multiplexed `boton` code into clean, debounced, one-shot key events. It accumulates decimal digits into a BCD entry buffer with clear and backspace. Committed numbers are handed to the consumer (calculator/display logic) over a valid/ready handshake.

## Interface
- `SCAN_PERIOD`, 200: cycles per full column sweep of the scanner (4 × its column dwell); length of one observation window.
- `DEBOUNCE_WIN`, 5: consecutive identical window results needed to accept a new stable code (≥1).
- `N_DIGITS`, 4: BCD digits in entry buffer and output (≥1).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `boton`  in  4  scanner code; 4'hF = no key; 0–9 digits, A/B/C/D letters, E = `*`.
- `entrada`  out  4·N_DIGITS  live BCD entry buffer, least-significant digit in [3:0] (for display).
- `n_dig`  out  $clog2(N_DIGITS+1)  digits currently in buffer.
- `tecla_evento`  out  1  one-cycle pulse per accepted key press.
- `tecla_codigo`  out  4  code of last accepted press.
- `dato`  out  4·N_DIGITS  committed BCD value.
- `dato_valido`  out  1  `dato` holds unconsumed value.
- `dato_listo`  in  1  consumer accepts `dato`.

## Operation
- Window sampler: counter `ventana` runs 0..SCAN_PERIOD-1 and wraps.
  - The first non-F `boton` seen in the window is latched. Later codes in the same window are ignored.
  - At `ventana == SCAN_PERIOD-1`, the window closes. The result is the latched code, or F if none (a sample taken in that closing cycle counts). The latch then clears for the next window.
- Debounce: at each window close, compare the result to the previous result.
  - Equal: increment the run counter, saturating at DEBOUNCE_WIN.
  - Different: set the run counter to 1.
  - When the run counter reaches DEBOUNCE_WIN and the result differs from the stable code, the stable code updates.
  - DEBOUNCE_WIN = 1 → the stable code follows each window result.
- Press FSM, states REPOSO, PULSADA:
  - REPOSO → PULSADA when the stable code changes F → non-F. Fire `tecla_evento`, load `tecla_codigo`, execute the action.
  - PULSADA → REPOSO when the stable code returns to F.
  - A stable change from one non-F code to another non-F code produces no event (release required).
- Actions (applied in the same cycle as `tecla_evento`):
  - Digit 0–9: if `n_dig` < N_DIGITS, shift the buffer left one digit, insert the digit at [3:0], `n_dig`+1. If full, ignore (event still fires).
  - E (`*`): buffer = 0, `n_dig` = 0.
  - B: if `n_dig` > 0, shift the buffer right one digit (zero fill at top), `n_dig`−1. Otherwise no-op.
  - A (commit): accepted if `n_dig` > 0 and (`dato_valido` = 0 or `dato_listo` = 1 this cycle).
    - On accept: `dato` ← buffer, `dato_valido` = 1, buffer and `n_dig` cleared.
    - Otherwise ignored; buffer retained.
  - C, D: event only, no action.
- Handshake: `dato_valido` stays high and `dato` stays frozen until a cycle with `dato_listo` = 1.
  - `dato_valido` drops the next cycle, unless an accepted commit reloads it that same cycle.
  - `dato_listo` while `dato_valido` = 0 is ignored.

## Timing
- Reset (async assert, sync release), all outputs:
  - `entrada`, `n_dig`, `dato` = 0.
  - `dato_valido` = 0, `tecla_evento` = 0.
  - `tecla_codigo` = 4'hF.
- Reset internal state:
  - stable code F, previous result F, run counter 0.
  - `ventana` 0, latch empty, FSM REPOSO.
- All outputs are registered.
- Press latency: key held continuously from the start of window 0, with stable code F beforehand.
  - `tecla_evento` is high in the cycle after the close of window DEBOUNCE_WIN-1.
  - That is cycle DEBOUNCE_WIN·SCAN_PERIOD after the first window cycle.
- Release latency: the same, measured from the first all-F window.
- A press shorter than DEBOUNCE_WIN windows, or a glitch, produces no event.
- `rst_n` mid-press or mid-handshake clears everything immediately. A key still held after release of `rst_n` is treated as a new press (stable starts at F).
- Minimum key-to-key rate: one event per 2·DEBOUNCE_WIN windows.

## Test plan
Bench settings: SCAN_PERIOD=8, DEBOUNCE_WIN=3, N_DIGITS=4, `boton` modelled as key code for 2 of 8 cycles and F otherwise.
- Reset, then press `1` for 5 windows and release → exactly one `tecla_evento` at cycle 24, `tecla_codigo`=1, `entrada`=16'h0001, `n_dig`=1.
- Type 1,2,3,4,5 (each press and release ≥3 windows) → `entrada`=16'h1234, `n_dig`=4, five events; the `5` is ignored.
- Then B, then E → after B `entrada`=16'h0123, `n_dig`=3; after E both 0.
- Type 7,8, then A with `dato_listo`=0 → `dato`=16'h0078, `dato_valido`=1, buffer cleared.
  - Then type 9, press A → commit ignored, `entrada`=16'h0009 kept.
  - Raise `dato_listo` for 1 cycle → `dato_valido`=0 next cycle.
- Glitch: `1` present for 2 windows, then F → no event, buffer unchanged. Press `1`, then slide to `2` without a release window → single event (code 1).
- Hold `5` and pulse `rst_n` low mid-press → all outputs at reset values. After release of `rst_n`, an event with code 5 follows 3 windows later.
